// File: rtl/mult_seq.sv
// Sequential unsigned 32x32->64 shift-and-add multiplier.
// A single ripple adder instance is time-shared, one partial-product add per cycle.

module adder #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    input  logic             i_cin,
    output logic [WIDTH-1:0] o_result,
    output logic             o_cout
);
    logic [WIDTH:0] carry;

    assign carry[0] = i_cin;

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        assign o_result[i]  = i_a[i] ^ i_b[i] ^ carry[i];
        assign carry[i+1]   = (i_a[i] & i_b[i]) | (carry[i] & (i_a[i] ^ i_b[i]));
    end

    assign o_cout = carry[WIDTH];
endmodule

// state | meaning
// IDLE  | waiting for i_start; operands and product held
// RUN   | 32 shift-and-add iterations, one per edge
// DONE  | product final, o_done pulsed for this one cycle
module mult_seq #(
    parameter int WIDTH = 32
) (
    input  logic               i_clk,
    input  logic               i_reset,
    input  logic               i_start,
    input  logic [WIDTH-1:0]   i_a,
    input  logic [WIDTH-1:0]   i_b,
    output logic               o_busy,
    output logic               o_done,
    output logic [2*WIDTH-1:0] o_product
);
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] m_q, m_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0] q_q, q_d;
    logic [4:0]       cnt_q, cnt_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    logic [WIDTH-1:0] sum;
    logic             c;

    adder #(.WIDTH(WIDTH)) u_adder (
        .i_a      (acc_q),
        .i_b      (q_q[0] ? m_q : '0),
        .i_cin    (1'b0),
        .o_result (sum),
        .o_cout   (c)
    );

    always_comb begin
        state_d = state_q;
        m_d     = m_q;
        acc_d   = acc_q;
        q_d     = q_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (i_start) begin
                    m_d     = i_a;
                    acc_d   = '0;
                    q_d     = i_b;
                    cnt_d   = 5'd0;
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                // {c, sum, q} shifted right by one; the carry lands in acc MSB.
                acc_d = {c, sum[WIDTH-1:1]};
                q_d   = {sum[0], q_q[WIDTH-1:1]};
                cnt_d = cnt_q + 5'd1;
                if (cnt_q == 5'd31) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
        busy_d = (state_d != ST_IDLE);
        done_d = (state_d == ST_DONE);
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q <= ST_IDLE;
            m_q     <= '0;
            acc_q   <= '0;
            q_q     <= '0;
            cnt_q   <= 5'd0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            m_q     <= m_d;
            acc_q   <= acc_d;
            q_q     <= q_d;
            cnt_q   <= cnt_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign o_busy    = busy_q;
    assign o_done    = done_q;
    assign o_product = {acc_q, q_q};
endmodule

// File: tb/tb_mult_seq.sv
// Randomized self-checking bench for mult_seq against a plain a*b reference.

module tb_mult_seq;
    logic        i_clk = 1'b0;
    logic        i_reset;
    logic        i_start;
    logic [31:0] i_a;
    logic [31:0] i_b;
    logic        o_busy;
    logic        o_done;
    logic [63:0] o_product;

    int total = 0;
    int bad   = 0;

    mult_seq #(.WIDTH(32)) dut (
        .i_clk     (i_clk),
        .i_reset   (i_reset),
        .i_start   (i_start),
        .i_a       (i_a),
        .i_b       (i_b),
        .o_busy    (o_busy),
        .o_done    (o_done),
        .o_product (o_product)
    );

    always #5 i_clk = ~i_clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge i_clk);
        #1;
    endtask

    function automatic logic [63:0] ref_mul(input logic [31:0] a, input logic [31:0] b);
        logic [63:0] wa, wb;
        wa = {32'h0, a};
        wb = {32'h0, b};
        return wa * wb;
    endfunction

    // Starts an operation from IDLE and waits for done; returns in the first IDLE cycle after DONE.
    task automatic run_op(input logic [31:0] a, input logic [31:0] b, input string tag);
        int n;
        int busy_cnt;
        logic [63:0] exp;
        exp = ref_mul(a, b);
        i_a = a;
        i_b = b;
        i_start = 1'b1;
        step();
        i_start = 1'b0;
        i_a = $urandom;
        i_b = $urandom;
        chk({tag, " busy_after_accept"}, {63'h0, o_busy}, 64'h1);
        chk({tag, " intermediate"}, o_product, {32'h0, b});
        n = 0;
        busy_cnt = 1;
        do begin
            step();
            n++;
            if (o_busy) busy_cnt++;
        end while (!o_done && n < 40);
        chk({tag, " latency"}, 64'(n), 64'd32);
        chk({tag, " busy_cycles"}, 64'(busy_cnt), 64'd33);
        chk({tag, " product"}, o_product, exp);
        step();
        chk({tag, " done_cleared"}, {63'h0, o_done}, 64'h0);
        chk({tag, " busy_cleared"}, {63'h0, o_busy}, 64'h0);
        chk({tag, " product_hold"}, o_product, exp);
    endtask

    task automatic count_done(input int cycles, output int seen);
        seen = 0;
        for (int k = 0; k < cycles; k++) begin
            step();
            if (o_done) seen++;
        end
    endtask

    initial begin
        int n;
        int seen;
        logic [31:0] ra, rb;

        i_reset = 1'b1;
        i_start = 1'b0;
        i_a = '0;
        i_b = '0;
        step();
        step();
        chk("rst busy", {63'h0, o_busy}, 64'h0);
        chk("rst done", {63'h0, o_done}, 64'h0);
        chk("rst product", o_product, 64'h0);

        // Reset wins over a simultaneous start.
        i_start = 1'b1;
        i_a = 32'd4;
        i_b = 32'd4;
        step();
        chk("rst_prio busy", {63'h0, o_busy}, 64'h0);
        i_start = 1'b0;
        i_reset = 1'b0;
        step();

        run_op(32'd3, 32'd5, "basic");
        run_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, "max");
        run_op(32'h0, 32'hDEAD_BEEF, "zero");
        run_op(32'h8000_0000, 32'd2, "msb");
        run_op(32'h1234_5678, 32'h9ABC_DEF0, "mixed");
        chk("mixed const", o_product, 64'h0B00_EA4E_242D_2080);

        // Starts while busy are dropped.
        i_a = 32'd7;
        i_b = 32'd6;
        i_start = 1'b1;
        step();
        i_start = 1'b0;
        repeat (5) step();
        i_a = 32'd9;
        i_b = 32'd9;
        i_start = 1'b1;
        step();
        i_start = 1'b0;
        n = 6;
        while (!o_done && n < 40) begin
            step();
            n++;
        end
        chk("busy_start latency", 64'(n), 64'd32);
        chk("busy_start product", o_product, 64'd42);
        i_a = 32'd9;
        i_b = 32'd9;
        i_start = 1'b1;
        step();
        i_start = 1'b0;
        chk("done_start ignored", {63'h0, o_busy}, 64'h0);
        count_done(40, seen);
        chk("busy_start extra_done", 64'(seen), 64'd0);
        chk("busy_start product_hold", o_product, 64'd42);
        run_op(32'd11, 32'd13, "after_busy");

        // Reset in the middle of RUN abandons the operation.
        i_a = 32'd100;
        i_b = 32'd100;
        i_start = 1'b1;
        step();
        i_start = 1'b0;
        repeat (9) step();
        i_reset = 1'b1;
        step();
        i_reset = 1'b0;
        chk("midrst busy", {63'h0, o_busy}, 64'h0);
        chk("midrst product", o_product, 64'h0);
        count_done(40, seen);
        chk("midrst no_done", 64'(seen), 64'd0);
        run_op(32'd2, 32'd3, "after_rst");

        // Back-to-back random operations, each started in the first IDLE cycle.
        for (int t = 0; t < 1000; t++) begin
            ra = $urandom;
            rb = $urandom;
            case (t % 50)
                0: ra = 32'hFFFF_FFFF;
                1: rb = 32'h0;
                2: rb = 32'hFFFF_FFFF;
                default: ;
            endcase
            run_op(ra, rb, "rand");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
